// File: rtl/maze_solve_ctrl_if.sv
// Signal bundle between the maze solver sequencer and its environment:
// maze stream in, map store writes out, search core handshake, result port.
interface maze_solve_ctrl_if;
   logic       maze;
   logic       in_valid;
   logic       map_we;
   logic [7:0] map_addr;
   logic       map_wdata;
   logic       solve_start;
   logic       solve_abort;
   logic       solve_done;
   logic       solve_fail;
   logic       step_valid;
   logic [3:0] step_x;
   logic [3:0] step_y;
   logic       step_last;
   logic       step_ready;
   logic       busy;
   logic       out_valid;
   logic       maze_not_valid;
   logic [3:0] out_x;
   logic [3:0] out_y;

   modport master (
      output maze, in_valid, solve_done, solve_fail,
             step_valid, step_x, step_y, step_last,
      input  map_we, map_addr, map_wdata, solve_start, solve_abort,
             step_ready, busy, out_valid, maze_not_valid, out_x, out_y
   );

   modport slave (
      input  maze, in_valid, solve_done, solve_fail,
             step_valid, step_x, step_y, step_last,
      output map_we, map_addr, map_wdata, solve_start, solve_abort,
             step_ready, busy, out_valid, maze_not_valid, out_x, out_y
   );
endinterface

// File: rtl/maze_solve_ctrl.sv
// Top-level sequencer of the 15x15 maze solver: loads the serial maze into the
// map store, screens entrance/exit, runs the search core with a timeout and forwards the path.
module maze_solve_ctrl #(
   parameter int N       = 15,
   parameter int TIMEOUT = 1023,
   parameter int TW      = 10
) (
   input logic              clk,
   input logic              rst_n,
   maze_solve_ctrl_if.slave bus
);

   localparam logic [7:0]    LAST_IDX     = 8'(N * N - 1);
   localparam logic [7:0]    ENTRY_IDX    = 8'(N + 1);
   localparam logic [7:0]    EXIT_IDX     = 8'((N - 2) * N + (N - 2));
   localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      CHECK,
      SOLVE,
      DRAIN,
      FAIL
   } state_t;

   state_t          state_q, state_d;
   logic [7:0]      bitCnt_q, bitCnt_d;
   logic            blocked_q, blocked_d;
   logic [TW-1:0]   timeoutCnt_q, timeoutCnt_d;
   logic            lastSeen_q, lastSeen_d;
   logic            mapWe_q, mapWe_d;
   logic [7:0]      mapAddr_q, mapAddr_d;
   logic            mapWdata_q, mapWdata_d;
   logic            outValid_q, outValid_d;
   logic            notValid_q, notValid_d;
   logic [3:0]      outX_q, outX_d;
   logic [3:0]      outY_q, outY_d;

   logic            capture;
   logic [7:0]      captureIdx;
   logic            solveStart;
   logic            solveAbort;
   logic            stepReady;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         bitCnt_q     <= '0;
         blocked_q    <= 1'b0;
         timeoutCnt_q <= '0;
         lastSeen_q   <= 1'b0;
         mapWe_q      <= 1'b0;
         mapAddr_q    <= '0;
         mapWdata_q   <= 1'b0;
         outValid_q   <= 1'b0;
         notValid_q   <= 1'b0;
         outX_q       <= '0;
         outY_q       <= '0;
      end else begin
         state_q      <= state_d;
         bitCnt_q     <= bitCnt_d;
         blocked_q    <= blocked_d;
         timeoutCnt_q <= timeoutCnt_d;
         lastSeen_q   <= lastSeen_d;
         mapWe_q      <= mapWe_d;
         mapAddr_q    <= mapAddr_d;
         mapWdata_q   <= mapWdata_d;
         outValid_q   <= outValid_d;
         notValid_q   <= notValid_d;
         outX_q       <= outX_d;
         outY_q       <= outY_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      bitCnt_d     = bitCnt_q;
      blocked_d    = blocked_q;
      timeoutCnt_d = timeoutCnt_q;
      lastSeen_d   = lastSeen_q;
      capture      = 1'b0;
      solveStart   = 1'b0;
      solveAbort   = 1'b0;
      stepReady    = 1'b0;
      outValid_d   = 1'b0;
      notValid_d   = 1'b0;
      outX_d       = '0;
      outY_d       = '0;

      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               capture   = 1'b1;
               bitCnt_d  = 8'd1;
               blocked_d = 1'b0;
               state_d   = LOAD;
            end
         end
         LOAD: begin
            if (bus.in_valid) begin
               capture = 1'b1;
               if (bitCnt_q == LAST_IDX) begin
                  bitCnt_d = '0;
                  state_d  = CHECK;
               end else begin
                  bitCnt_d = bitCnt_q + 8'd1;
               end
            end
         end
         CHECK: begin
            if (blocked_q) begin
               outValid_d = 1'b1;
               notValid_d = 1'b1;
               state_d    = FAIL;
            end else begin
               solveStart   = 1'b1;
               timeoutCnt_d = '0;
               state_d      = SOLVE;
            end
         end
         SOLVE: begin
            // A simultaneous done and fail is treated as a failure.
            timeoutCnt_d = timeoutCnt_q + 1'b1;
            if (bus.solve_fail) begin
               outValid_d = 1'b1;
               notValid_d = 1'b1;
               state_d    = FAIL;
            end else if (bus.solve_done) begin
               lastSeen_d = 1'b0;
               state_d    = DRAIN;
            end else if (timeoutCnt_q == TIMEOUT_LAST) begin
               solveAbort = 1'b1;
               outValid_d = 1'b1;
               notValid_d = 1'b1;
               state_d    = FAIL;
            end
         end
         DRAIN: begin
            // Stay one extra cycle after the final step so busy covers its output.
            if (lastSeen_q) begin
               lastSeen_d = 1'b0;
               state_d    = IDLE;
            end else begin
               stepReady = 1'b1;
               if (bus.step_valid) begin
                  outValid_d = 1'b1;
                  outX_d     = bus.step_x;
                  outY_d     = bus.step_y;
                  lastSeen_d = bus.step_last;
               end
            end
         end
         FAIL: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      captureIdx = (state_q == IDLE) ? 8'd0 : bitCnt_q;
      if (capture && bus.maze && (captureIdx == ENTRY_IDX || captureIdx == EXIT_IDX)) begin
         blocked_d = 1'b1;
      end
      mapWe_d    = capture;
      mapAddr_d  = capture ? captureIdx : mapAddr_q;
      mapWdata_d = capture ? bus.maze : mapWdata_q;
   end

   assign bus.map_we         = mapWe_q;
   assign bus.map_addr       = mapAddr_q;
   assign bus.map_wdata      = mapWdata_q;
   assign bus.solve_start    = solveStart;
   assign bus.solve_abort    = solveAbort;
   assign bus.step_ready     = stepReady;
   assign bus.busy           = (state_q != IDLE);
   assign bus.out_valid      = outValid_q;
   assign bus.maze_not_valid = notValid_q;
   assign bus.out_x          = outX_q;
   assign bus.out_y          = outY_q;

endmodule

// File: tb/tb_maze_solve_ctrl.sv
// Directed bench for maze_solve_ctrl: open, blocked, timeout, done+fail,
// gapped load and mid-load reset scenarios with hand-computed expectations.
module tb_maze_solve_ctrl;

   logic clk;
   logic rst_n;
   maze_solve_ctrl_if bus();

   maze_solve_ctrl dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   nAsserts = 0;
   int   nFail    = 0;
   logic mazeBits [256];

   int wrCount, wrErr, startCnt, abortCnt, outCnt, invErr;

   // Observes the map writes and output port on the falling edge.
   always @(negedge clk) begin
      if (bus.map_we === 1'b1) begin
         if (bus.map_addr !== wrCount[7:0] || bus.map_wdata !== mazeBits[bus.map_addr]) wrErr++;
         wrCount++;
      end
      if (bus.solve_start === 1'b1) startCnt++;
      if (bus.solve_abort === 1'b1) abortCnt++;
      if (bus.out_valid === 1'b1) outCnt++;
      if (bus.out_valid !== 1'b1 && (bus.out_x !== 4'd0 || bus.out_y !== 4'd0 || bus.maze_not_valid !== 1'b0))
         invErr++;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      nAsserts++;
      assert (observed === expected) else begin
         nFail++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clearCounters();
      wrCount  = 0;
      wrErr    = 0;
      startCnt = 0;
      abortCnt = 0;
      outCnt   = 0;
   endtask

   task automatic makeMaze(input bit blockEntry, input bit blockExit);
      for (int i = 0; i < 256; i++) mazeBits[i] = (i < 225) && (i % 7 == 3);
      mazeBits[16]  = blockEntry;
      mazeBits[208] = blockExit;
   endtask

   task automatic applyStimulus(input int nBits, input int nGaps);
      bit gapAt [225];
      int placed;
      int p;
      placed = 0;
      while (placed < nGaps) begin
         p = $urandom_range(1, 224);
         if (!gapAt[p]) begin
            gapAt[p] = 1'b1;
            placed++;
         end
      end
      for (int i = 0; i < nBits; i++) begin
         if (gapAt[i]) begin
            bus.in_valid = 1'b0;
            bus.maze     = 1'($urandom_range(0, 1));
            tick();
         end
         bus.in_valid = 1'b1;
         bus.maze     = mazeBits[i];
         tick();
      end
      bus.in_valid = 1'b0;
      bus.maze     = 1'b0;
   endtask

   // Path (1,1) down column 1 to (13,1), then along row 13 to (13,13): 25 steps.
   task automatic drainPath();
      logic [3:0] x, y;
      checkOutput("readyInDrain", bus.step_ready, 1);
      for (int i = 0; i < 25; i++) begin
         if (i % 6 == 5) begin
            bus.step_valid = 1'b0;
            bus.step_x     = 4'd7;
            bus.step_y     = 4'd9;
            tick();
            checkOutput("gapNoOutput", bus.out_valid, 0);
         end
         x = (i < 13) ? 4'(i + 1) : 4'd13;
         y = (i < 13) ? 4'd1 : 4'(i - 11);
         bus.step_valid = 1'b1;
         bus.step_x     = x;
         bus.step_y     = y;
         bus.step_last  = (i == 24);
         tick();
         checkOutput("stepValid", bus.out_valid, 1);
         checkOutput("stepX", bus.out_x, x);
         checkOutput("stepY", bus.out_y, y);
         checkOutput("stepNotValid", bus.maze_not_valid, 0);
      end
      bus.step_valid = 1'b0;
      bus.step_last  = 1'b0;
      checkOutput("lastX", bus.out_x, 13);
      checkOutput("lastY", bus.out_y, 13);
      checkOutput("busyAtLastOut", bus.busy, 1);
      checkOutput("readyAfterLast", bus.step_ready, 0);
      tick();
      checkOutput("busyDropped", bus.busy, 0);
      checkOutput("idleNoOut", bus.out_valid, 0);
   endtask

   initial begin
      rst_n          = 1'b0;
      bus.maze       = 1'b0;
      bus.in_valid   = 1'b0;
      bus.solve_done = 1'b0;
      bus.solve_fail = 1'b0;
      bus.step_valid = 1'b0;
      bus.step_x     = 4'd0;
      bus.step_y     = 4'd0;
      bus.step_last  = 1'b0;
      invErr         = 0;
      clearCounters();
      makeMaze(1'b0, 1'b0);
      repeat (3) tick();
      checkOutput("rstBusy", bus.busy, 0);
      checkOutput("rstMapWe", bus.map_we, 0);
      checkOutput("rstOutValid", bus.out_valid, 0);
      checkOutput("rstStart", bus.solve_start, 0);
      rst_n = 1'b1;
      tick();

      $display("[TB] open maze with gapped stream");
      clearCounters();
      applyStimulus(225, 10);
      checkOutput("checkBusy", bus.busy, 1);
      checkOutput("startInCheck", bus.solve_start, 1);
      tick();
      checkOutput("startOnce", bus.solve_start, 0);
      checkOutput("writeCount", wrCount, 225);
      checkOutput("writeOrder", wrErr, 0);
      bus.solve_done = 1'b1;
      tick();
      bus.solve_done = 1'b0;
      drainPath();
      checkOutput("openStartCnt", startCnt, 1);
      checkOutput("openOutCnt", outCnt, 25);
      checkOutput("openAbortCnt", abortCnt, 0);

      $display("[TB] entrance and exit walled");
      for (int v = 0; v < 2; v++) begin
         makeMaze(v == 0, v == 1);
         clearCounters();
         applyStimulus(225, 0);
         checkOutput("blkNoStart", bus.solve_start, 0);
         checkOutput("blkCheckNoOut", bus.out_valid, 0);
         tick();
         checkOutput("blkOutValid", bus.out_valid, 1);
         checkOutput("blkNotValid", bus.maze_not_valid, 1);
         checkOutput("blkOutX", bus.out_x, 0);
         checkOutput("blkOutY", bus.out_y, 0);
         tick();
         checkOutput("blkIdle", bus.busy, 0);
         checkOutput("blkOneOut", bus.out_valid, 0);
         checkOutput("blkStartCnt", startCnt, 0);
         checkOutput("blkWrites", wrCount, 225);
      end

      $display("[TB] core never responds");
      makeMaze(1'b0, 1'b0);
      clearCounters();
      applyStimulus(225, 0);
      tick();
      checkOutput("toCycle1NoAbort", bus.solve_abort, 0);
      repeat (1022) tick();
      checkOutput("toNoEarlyAbort", abortCnt, 0);
      checkOutput("toAbortAt1023", bus.solve_abort, 1);
      checkOutput("toBusy", bus.busy, 1);
      tick();
      checkOutput("toFailValid", bus.out_valid, 1);
      checkOutput("toFailNotValid", bus.maze_not_valid, 1);
      checkOutput("toAbortCnt", abortCnt, 1);
      bus.solve_done = 1'b1;
      bus.solve_fail = 1'b1;
      bus.step_valid = 1'b1;
      tick();
      checkOutput("toIdleOut", bus.out_valid, 0);
      tick();
      checkOutput("toIgnoreBusy", bus.busy, 0);
      checkOutput("toIgnoreReady", bus.step_ready, 0);
      bus.solve_done = 1'b0;
      bus.solve_fail = 1'b0;
      bus.step_valid = 1'b0;
      checkOutput("toStartCnt", startCnt, 1);
      checkOutput("toAbortOnce", abortCnt, 1);

      $display("[TB] done and fail together");
      clearCounters();
      applyStimulus(225, 0);
      tick();
      bus.solve_done = 1'b1;
      bus.solve_fail = 1'b1;
      tick();
      bus.solve_done = 1'b0;
      bus.solve_fail = 1'b0;
      checkOutput("dfOutValid", bus.out_valid, 1);
      checkOutput("dfNotValid", bus.maze_not_valid, 1);
      checkOutput("dfNoReady", bus.step_ready, 0);
      bus.step_valid = 1'b1;
      bus.step_x     = 4'd5;
      bus.step_y     = 4'd6;
      tick();
      checkOutput("dfIdle", bus.busy, 0);
      checkOutput("dfNoDrain", bus.out_valid, 0);
      tick();
      bus.step_valid = 1'b0;
      checkOutput("dfOutCnt", outCnt, 1);

      $display("[TB] reset during load");
      makeMaze(1'b0, 1'b0);
      clearCounters();
      applyStimulus(101, 0);
      checkOutput("preRstMapWe", bus.map_we, 1);
      checkOutput("preRstAddr", bus.map_addr, 100);
      rst_n = 1'b0;
      #1;
      checkOutput("midRstMapWe", bus.map_we, 0);
      checkOutput("midRstAddr", bus.map_addr, 0);
      checkOutput("midRstBusy", bus.busy, 0);
      checkOutput("midRstOut", bus.out_valid, 0);
      tick();
      tick();
      checkOutput("heldRstBusy", bus.busy, 0);
      rst_n = 1'b1;
      clearCounters();
      applyStimulus(225, 3);
      checkOutput("reloadStart", bus.solve_start, 1);
      tick();
      checkOutput("reloadWrites", wrCount, 225);
      checkOutput("reloadOrder", wrErr, 0);
      bus.solve_done = 1'b1;
      tick();
      bus.solve_done = 1'b0;
      drainPath();
      checkOutput("reloadOutCnt", outCnt, 25);

      checkOutput("zeroWhenInvalid", invErr, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
      $finish;
   end

endmodule
